osbm_arb: RTL and testbench

//  Output-side switch buffer manager. There is one instance per switch output port.
//  It receives the per-input request lines driven by the input-side managers and

---
 rtl/osbm_arb.sv | 134 +++++++++++++
 tb/tb_osbm_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osbm_arb.sv
// Output-side switch buffer manager: round-robin grant with packet locking,
// steering the granted input's words to the output link with one-cycle latency.
module osbm_arb #(
   parameter int         DW       = 32,
   parameter int         IDLE_MAX = 16,
   parameter int         PORT     = 3,
   parameter logic [1:0] TAIL     = 2'd2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PORT:0]         req,
   output logic [PORT:0]         ack,
   input  logic [PORT:0]         vin,
   input  logic [2*PORT+1:0]     pin,
   input  logic [DW*(PORT+1)-1:0] din,
   output logic                  we,
   output logic [1:0]            pout,
   output logic [DW-1:0]         dout
);

   localparam int NP = PORT + 1;
   localparam int GW = (NP > 1) ? $clog2(NP) : 1;
   localparam int WW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
   localparam logic [WW-1:0] WD_MAX  = WW'(IDLE_MAX);
   localparam logic [WW-1:0] WD_LAST = WW'((IDLE_MAX > 0) ? IDLE_MAX - 1 : 0);
   localparam logic [GW-1:0] PTR_RST = GW'(PORT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_n;
   logic [GW-1:0]   g, g_n, ptr, ptr_n, win;
   logic [WW-1:0]   wdog, wdog_n;
   logic [PORT:0]   ack_n;
   logic            we_n;
   logic [1:0]      pout_n;
   logic [DW-1:0]   dout_n;
   logic            vg, rg, tail, wd_exp;
   logic [1:0]      pg;
   logic [DW-1:0]   dg;

   always_comb begin
      vg = 1'b0;
      rg = 1'b0;
      pg = '0;
      dg = '0;
      for (int i = 0; i < NP; i++) begin
         if (g == GW'(i)) begin
            vg = vin[i];
            rg = req[i];
            pg = pin[2*i +: 2];
            dg = din[DW*i +: DW];
         end
      end
      tail   = vg && (pg == TAIL);
      wd_exp = (IDLE_MAX != 0) && !vg && (wdog == WD_LAST);
   end

   // Winner is the requester at the smallest distance past ptr.
   always_comb begin
      int best;
      int d;
      best = NP;
      d    = 0;
      win  = ptr;
      for (int i = 0; i < NP; i++) begin
         d = (i - int'(ptr) - 1 + 2*NP) % NP;
         if (req[i] && d < best) begin
            best = d;
            win  = GW'(i);
         end
      end
   end

   always_comb begin
      state_n = state;
      g_n     = g;
      ptr_n   = ptr;
      wdog_n  = wdog;
      we_n    = 1'b0;
      pout_n  = pout;
      dout_n  = dout;
      ack_n   = '0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = BUSY;
               g_n     = win;
               wdog_n  = '0;
            end
         end
         BUSY: begin
            we_n = vg && rg;
            if (vg && rg) begin
               pout_n = pg;
               dout_n = dg;
            end
            if (vg)
               wdog_n = '0;
            else if (wdog != WD_MAX)
               wdog_n = wdog + 1'b1;
            if (tail || !rg || wd_exp) begin
               state_n = IDLE;
               ptr_n   = g;
            end
         end
         default: ;
      endcase
      for (int i = 0; i < NP; i++)
         ack_n[i] = (state_n == BUSY) && (g_n == GW'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         g     <= '0;
         ptr   <= PTR_RST;
         wdog  <= '0;
         ack   <= '0;
         we    <= 1'b0;
         pout  <= '0;
         dout  <= '0;
      end else begin
         state <= state_n;
         g     <= g_n;
         ptr   <= ptr_n;
         wdog  <= wdog_n;
         ack   <= ack_n;
         we    <= we_n;
         pout  <= pout_n;
         dout  <= dout_n;
      end
   end

endmodule

// File: tb/tb_osbm_arb.sv
// Bench for osbm_arb: directed packet scenarios plus randomized traffic
// against a transaction-level arbiter model (watchdog 4 and disabled).
module tb_osbm_arb;

   localparam int DW = 32;
   localparam logic [1:0] DATA = 2'd0;
   localparam logic [1:0] HEAD = 2'd1;
   localparam logic [1:0] TAIL = 2'd2;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req, vin;
   logic [7:0]   pin;
   logic [127:0] din;
   logic [3:0]   ack, ack0;
   logic         we, we0;
   logic [1:0]   pout, pout0;
   logic [31:0]  dout, dout0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   osbm_arb #(.DW(DW), .IDLE_MAX(4), .PORT(3), .TAIL(TAIL)) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack), .vin(vin), .pin(pin),
      .din(din), .we(we), .pout(pout), .dout(dout)
   );

   osbm_arb #(.DW(DW), .IDLE_MAX(0), .PORT(3), .TAIL(TAIL)) dut0 (
      .clk(clk), .rst(rst), .req(req), .ack(ack0), .vin(vin), .pin(pin),
      .din(din), .we(we0), .pout(pout0), .dout(dout0)
   );

   // model state: index 0 follows dut (limit 4), index 1 follows dut0 (no limit)
   int          lim[2]    = '{4, 0};
   bit          m_busy[2] = '{0, 0};
   int          m_g[2]    = '{0, 0};
   int          m_ptr[2]  = '{3, 3};
   int          m_gap[2]  = '{0, 0};
   logic [3:0]  e_ack[2]  = '{4'd0, 4'd0};
   logic        e_we[2]   = '{1'b0, 1'b0};
   logic [1:0]  e_pout[2] = '{2'd0, 2'd0};
   logic [31:0] e_dout[2] = '{32'd0, 32'd0};

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_busy[m] = 0; m_ptr[m] = 3; m_gap[m] = 0;
            e_ack[m] = 0; e_we[m] = 0; e_pout[m] = 0; e_dout[m] = 0;
         end else if (!m_busy[m]) begin
            e_we[m]  = 0;
            e_ack[m] = 0;
            if (req != 0) begin
               bit got = 0;
               for (int k = 1; k <= 4; k++) begin
                  int c = (m_ptr[m] + k) % 4;
                  if (!got && req[c]) begin
                     got = 1;
                     m_g[m] = c;
                  end
               end
               m_busy[m] = 1;
               m_gap[m]  = 0;
               e_ack[m]  = 4'b0001 << m_g[m];
            end
         end else begin
            int g = m_g[m];
            bit v = vin[g];
            bit r = req[g];
            logic [1:0] p = pin[2*g +: 2];
            e_we[m] = v && r;
            if (v && r) begin
               e_pout[m] = p;
               e_dout[m] = din[32*g +: 32];
            end
            m_gap[m] = v ? 0 : m_gap[m] + 1;
            if (!r || (v && p == TAIL) || (lim[m] != 0 && m_gap[m] == lim[m])) begin
               m_busy[m] = 0;
               m_ptr[m]  = g;
               e_ack[m]  = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [1:0] p, input logic [31:0] d);
      vin = 4'b0001 << i;
      pin[2*i +: 2] = p;
      din[32*i +: 32] = d;
   endtask

   task automatic do_reset();
      rst = 1; req = 0; vin = 0;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; req = 0; vin = 0; pin = 0; din = 0;
      tick();
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we); end
      total++; if (pout !== 2'd0) begin bad++; $display("FAIL reset_pout got=%0d want=0", pout); end
      total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
      total++; if (ack0 !== 4'b0000) begin bad++; $display("FAIL reset_ack0 got=%b want=0000", ack0); end
      rst = 0;
   endtask

   task automatic test_single();
      logic [1:0]  tp[3] = '{HEAD, DATA, TAIL};
      logic [31:0] dv[3] = '{32'hA1, 32'hA2, 32'hA3};
      req = 4'b0010; vin = 0;
      tick();
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b want=0010", ack); end
      for (int k = 0; k < 3; k++) begin
         put(1, tp[k], dv[k]);
         tick();
         total++; if (we !== 1'b1) begin bad++; $display("FAIL single_we%0d got=%b want=1", k, we); end
         total++; if (pout !== tp[k]) begin bad++; $display("FAIL single_pout%0d got=%0d want=%0d", k, pout, tp[k]); end
         total++; if (dout !== dv[k]) begin bad++; $display("FAIL single_dout%0d got=%h want=%h", k, dout, dv[k]); end
      end
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_release got=%b want=0000", ack); end
      req = 0; vin = 0;
      tick();
      total++; if (we !== 1'b0) begin bad++; $display("FAIL single_we_off got=%b want=0", we); end
   endtask

   task automatic test_two_req();
      do_reset();
      req = 4'b0101; vin = 0;
      tick();
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL two_first got=%b want=0001", ack); end
      put(0, HEAD, 32'h10);
      tick();
      put(0, TAIL, 32'h11);
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL two_gap got=%b want=0000", ack); end
      vin = 0;
      tick();
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL two_second got=%b want=0100", ack); end
      req = 0;
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      int got[$];
      do_reset();
      req = 4'b1111; vin = 0;
      for (int p = 0; p < 5; p++) begin
         int idx = -1;
         for (int c = 0; c < 8 && idx < 0; c++) begin
            tick();
            for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
         end
         total++;
         if (idx < 0) begin
            bad++; $display("FAIL rr_timeout pkt=%0d got=none want=grant", p);
            break;
         end
         got.push_back(idx);
         if (idx !== p % 4) begin bad++; $display("FAIL rr_order pkt=%0d got=%0d want=%0d", p, idx, p % 4); end
         put(idx, HEAD, 32'h100 + p);
         tick();
         put(idx, TAIL, 32'h200 + p);
         tick();
         vin = 0;
         total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rr_gap pkt=%0d got=%b want=0000", p, ack); end
      end
      req = 0;
      tick();
      tick();
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b0100; vin = 0;
      tick();
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL wd_grant got=%b want=0100", ack); end
      put(2, HEAD, 32'h22);
      tick();
      req = 4'b1001; vin = 0;
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL wd_drop got=%b want=0000", ack); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL wd_we got=%b want=0", we); end
      tick();
      total++; if (ack !== 4'b1000) begin bad++; $display("FAIL wd_next got=%b want=1000", ack); end
      req = 0;
      tick();
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      req = 4'b0010; vin = 0;
      tick();
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL dog_grant got=%b want=0010", ack); end
      total++; if (ack0 !== 4'b0010) begin bad++; $display("FAIL dog_grant0 got=%b want=0010", ack0); end
      repeat (3) tick();
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL dog_hold got=%b want=0010", ack); end
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL dog_expire got=%b want=0000", ack); end
      repeat (26) tick();
      total++; if (ack0 !== 4'b0010) begin bad++; $display("FAIL dog_off got=%b want=0010", ack0); end
      req = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; vin = 0;
      tick();
      put(0, HEAD, 32'h31);
      tick();
      rst = 1;
      put(0, DATA, 32'h32);
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rmid_ack got=%b want=0000", ack); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", we); end
      total++; if (pout !== 2'd0) begin bad++; $display("FAIL rmid_pout got=%0d want=0", pout); end
      total++; if (dout !== 32'd0) begin bad++; $display("FAIL rmid_dout got=%h want=0", dout); end
      rst = 0; vin = 0; req = 4'b0001;
      tick();
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rmid_regrant got=%b want=0001", ack); end
      req = 0;
      tick();
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            pin[2*i +: 2] = 2'($urandom_range(0, 3));
            din[32*i +: 32] = $urandom;
         end
         vin = 4'($urandom);
         tick();
         total++; if (ack !== e_ack[0]) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, ack, e_ack[0]); end
         total++; if (we !== e_we[0]) begin bad++; $display("FAIL rnd_we c=%0d got=%b want=%b", c, we, e_we[0]); end
         total++; if (pout !== e_pout[0]) begin bad++; $display("FAIL rnd_pout c=%0d got=%0d want=%0d", c, pout, e_pout[0]); end
         total++; if (dout !== e_dout[0]) begin bad++; $display("FAIL rnd_dout c=%0d got=%h want=%h", c, dout, e_dout[0]); end
         total++; if (ack0 !== e_ack[1]) begin bad++; $display("FAIL rnd_ack0 c=%0d got=%b want=%b", c, ack0, e_ack[1]); end
         total++; if (we0 !== e_we[1]) begin bad++; $display("FAIL rnd_we0 c=%0d got=%b want=%b", c, we0, e_we[1]); end
         total++; if (pout0 !== e_pout[1]) begin bad++; $display("FAIL rnd_pout0 c=%0d got=%0d want=%0d", c, pout0, e_pout[1]); end
         total++; if (dout0 !== e_dout[1]) begin bad++; $display("FAIL rnd_dout0 c=%0d got=%h want=%h", c, dout0, e_dout[1]); end
      end
      rst = 0; req = 0; vin = 0;
      tick();
   endtask

   initial begin
      rst = 1; req = 0; vin = 0; pin = 0; din = 0;
      test_reset();
      test_single();
      test_two_req();
      test_round_robin();
      test_withdraw();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
